// File: rtl/arb_pkg.sv
// Shared encodings for the sample-memory arbiter: FSM states, requester IDs,
// default bus widths and small ID/state mapping helpers.
package arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_H = 2'd1,
        OWN_E = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_H = 1'b0,
        REQ_E = 1'b1
    } req_id_t;

    function automatic req_id_t other_id(input req_id_t id);
        req_id_t v_res;
        if (id == REQ_H) begin
            v_res = REQ_E;
        end else begin
            v_res = REQ_H;
        end
        return v_res;
    endfunction

    function automatic arb_state_t own_state(input req_id_t id);
        arb_state_t v_res;
        if (id == REQ_H) begin
            v_res = OWN_H;
        end else begin
            v_res = OWN_E;
        end
        return v_res;
    endfunction

endpackage

// File: rtl/arb_rd_return.sv
// Read-return tracker: remembers which requester issued last cycle's read and
// steers the memory's one-cycle-late read data back to that requester only.
module arb_rd_return
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_issue,
    input  req_id_t           i_issuer,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_h_rvalid,
    output logic [DATA_W-1:0] o_h_rdata,
    output logic              o_e_rvalid,
    output logic [DATA_W-1:0] o_e_rdata
);

    logic    r_valid;
    req_id_t r_id;

    // Capture issue strobe and issuer; reset discards any read in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_id    <= REQ_H;
        end else begin
            r_valid <= i_rd_issue;
            r_id    <= i_issuer;
        end
    end

    // Memory data is only valid in the cycle after issue, so it is gated, not re-registered.
    always_comb begin
        o_h_rvalid = 1'b0;
        o_e_rvalid = 1'b0;
        o_h_rdata  = '0;
        o_e_rdata  = '0;
        if (r_valid && (r_id == REQ_H)) begin
            o_h_rvalid = 1'b1;
            o_h_rdata  = i_mem_rdata;
        end else if (r_valid && (r_id == REQ_E)) begin
            o_e_rvalid = 1'b1;
            o_e_rdata  = i_mem_rdata;
        end else begin
            o_h_rvalid = 1'b0;
            o_e_rvalid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port sample memory between the host
// loader (H, read/write) and the compute engine (E, read-only), with bounded lock.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              h_req,
    input  logic              h_lock,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              e_req,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    req_id_t           r_ptr;
    logic [HOLD_W-1:0] r_hold;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_own_req;
    logic              w_own_lock;
    logic              w_oth_req;
    req_id_t           w_issuer;
    arb_state_t        w_other_state;
    logic              w_rd_issue;

    // Owner view: route the current owner's request onto the memory port.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_own_req   = 1'b0;
        w_own_lock  = 1'b0;
        w_oth_req   = 1'b0;
        w_issuer    = REQ_H;
        case (r_state)
            OWN_H: begin
                w_mem_en    = h_req;
                w_mem_we    = h_we;
                w_mem_addr  = h_addr;
                w_mem_wdata = h_wdata;
                w_own_req   = h_req;
                w_own_lock  = h_lock;
                w_oth_req   = e_req;
                w_issuer    = REQ_H;
            end
            OWN_E: begin
                w_mem_en    = e_req;
                w_mem_addr  = e_addr;
                w_own_req   = e_req;
                w_own_lock  = e_lock;
                w_oth_req   = h_req;
                w_issuer    = REQ_E;
            end
            default: begin
                w_mem_en = 1'b0;
                w_mem_we = 1'b0;
            end
        endcase
    end

    assign w_other_state = own_state(other_id(w_issuer));
    assign w_rd_issue    = w_mem_en && !w_mem_we;

    // Next owner: an unlocked owner yields after one access; a locked one yields at the hold limit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (h_req && e_req) begin
                    w_state_nxt = own_state(r_ptr);
                end else if (h_req) begin
                    w_state_nxt = OWN_H;
                end else if (e_req) begin
                    w_state_nxt = OWN_E;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OWN_H, OWN_E: begin
                if (!w_own_req) begin
                    w_state_nxt = w_oth_req ? w_other_state : IDLE;
                end else if (w_oth_req && (!w_own_lock || (r_hold == HOLD_LAST))) begin
                    w_state_nxt = w_other_state;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Ownership FSM with round-robin pointer and saturating hold counter.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_ptr   <= REQ_H;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != IDLE) && (w_state_nxt != r_state)) begin
                r_hold <= '0;
                r_ptr  <= (w_state_nxt == OWN_H) ? REQ_E : REQ_H;
            end else if (w_state_nxt == IDLE) begin
                r_hold <= '0;
            end else if (w_mem_en && (r_hold != HOLD_LAST)) begin
                r_hold <= r_hold + HOLD_W'(1);
            end else begin
                r_hold <= r_hold;
            end
        end
    end

    assign h_gnt     = (r_state == OWN_H);
    assign e_gnt     = (r_state == OWN_E);
    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_we;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;

    arb_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .i_clk       (Clk),
        .i_rst_n     (Rst),
        .i_rd_issue  (w_rd_issue),
        .i_issuer    (w_issuer),
        .i_mem_rdata (mem_rdata),
        .o_h_rvalid  (h_rvalid),
        .o_h_rdata   (h_rdata),
        .o_e_rvalid  (e_rvalid),
        .o_e_rdata   (e_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory macro model, directed scenarios with literal
// expectations, then random traffic checked every cycle against a rule-level model.
module tb_mem_arbiter;

    localparam int MAX_HOLD = 16;

    logic       Clk;
    logic       Rst;
    logic       h_req, h_lock, h_we, e_req, e_lock;
    logic [7:0] h_addr, h_wdata, e_addr;
    logic       h_gnt, h_rvalid, e_gnt, e_rvalid;
    logic [7:0] h_rdata, e_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk(Clk), .Rst(Rst),
        .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_lock(e_lock), .e_addr(e_addr),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // 256x8 synchronous memory macro, preloaded on its first clock.
    logic [7:0] mem [256];
    bit mem_loaded = 1'b0;
    always @(posedge Clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 7) + 3);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=H 2=E; pointer 1=H 2=E.
    initial begin : model
        int m_own, m_ptr, m_hold, m_pid, m_pdata, nxt;
        bit m_pv;
        int own_req, x_lock, y_req, y;
        int e_en, e_we, e_addr_x, e_wd, rd_val;
        int shadow [256];
        for (int i = 0; i < 256; i++) shadow[i] = ((i * 7) + 3) % 256;
        m_own = 0; m_ptr = 1; m_hold = 0; m_pv = 0; m_pid = 0; m_pdata = 0;
        forever begin
            @(negedge Clk);
            #2;
            own_req  = (m_own == 1) ? int'(h_req) : (m_own == 2) ? int'(e_req) : 0;
            e_en     = own_req;
            e_we     = (m_own == 1) ? int'(h_we) : 0;
            e_addr_x = (m_own == 1) ? int'(h_addr) : (m_own == 2) ? int'(e_addr) : 0;
            e_wd     = (m_own == 1) ? int'(h_wdata) : 0;
            if (chk_en) begin
                chk("h_gnt", int'(h_gnt), int'(m_own == 1));
                chk("e_gnt", int'(e_gnt), int'(m_own == 2));
                chk("mem_en", int'(mem_en), e_en);
                chk("mem_we", int'(mem_we), e_we);
                chk("mem_addr", int'(mem_addr), e_addr_x);
                chk("mem_wdata", int'(mem_wdata), e_wd);
                chk("h_rvalid", int'(h_rvalid), int'(m_pv && m_pid == 1));
                chk("e_rvalid", int'(e_rvalid), int'(m_pv && m_pid == 2));
                if (m_pv && m_pid == 1) chk("h_rdata", int'(h_rdata), m_pdata);
                if (m_pv && m_pid == 2) chk("e_rdata", int'(e_rdata), m_pdata);
            end
            rd_val = shadow[e_addr_x];
            if (e_en != 0 && e_we != 0) shadow[e_addr_x] = e_wd;
            if (!Rst) begin
                m_own = 0; m_ptr = 1; m_hold = 0; m_pv = 0;
            end else begin
                m_pv = (e_en != 0) && (e_we == 0);
                m_pid = m_own;
                m_pdata = rd_val;
                if (m_own == 0) begin
                    if (h_req && e_req) nxt = m_ptr;
                    else if (h_req) nxt = 1;
                    else if (e_req) nxt = 2;
                    else nxt = 0;
                end else begin
                    x_lock = (m_own == 1) ? int'(h_lock) : int'(e_lock);
                    y_req  = (m_own == 1) ? int'(e_req) : int'(h_req);
                    y      = 3 - m_own;
                    if (own_req == 0) nxt = (y_req != 0) ? y : 0;
                    else if (y_req != 0 && (x_lock == 0 || m_hold == MAX_HOLD - 1)) nxt = y;
                    else nxt = m_own;
                end
                if (nxt != 0 && nxt != m_own) begin
                    m_hold = 0;
                    m_ptr = 3 - nxt;
                end else if (nxt == 0) begin
                    m_hold = 0;
                end else if (e_en != 0 && m_hold < MAX_HOLD - 1) begin
                    m_hold = m_hold + 1;
                end
                m_own = nxt;
            end
        end
    end

    task automatic cyc(input bit r, input bit hr, input bit hl, input bit hw,
                       input logic [7:0] ha, input logic [7:0] hd,
                       input bit er, input bit el, input logic [7:0] ea);
        @(negedge Clk);
        Rst = r; h_req = hr; h_lock = hl; h_we = hw; h_addr = ha; h_wdata = hd;
        e_req = er; e_lock = el; e_addr = ea;
        #3;
    endtask

    initial begin : driver
        int cnt;
        bit seen;
        Rst = 1'b0; h_req = 1'b0; h_lock = 1'b0; h_we = 1'b0; h_addr = 8'h00;
        h_wdata = 8'h00; e_req = 1'b0; e_lock = 1'b0; e_addr = 8'h00;
        @(posedge Clk);
        chk_en = 1'b1;

        // Reset held with both requesting
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("rst_h_gnt", int'(h_gnt), 0);
        chk("rst_e_gnt", int'(e_gnt), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_rvalid", int'(h_rvalid | e_rvalid), 0);
        chk("rst_rdata", int'(h_rdata | e_rdata), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("post_rst_h_first", int'(h_gnt), 1);
        chk("post_rst_e_idle", int'(e_gnt), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // Host write 0xA5 to 0x10, then read it back
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00);
        chk("wr_h_gnt", int'(h_gnt), 1);
        chk("wr_mem_we", int'(mem_we), 1);
        chk("wr_mem_addr", int'(mem_addr), 8'h10);
        chk("wr_mem_wdata", int'(mem_wdata), 8'hA5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rd_issue_we", int'(mem_we), 0);
        chk("wr_no_rvalid", int'(h_rvalid), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rd_h_rvalid", int'(h_rvalid), 1);
        chk("rd_h_rdata", int'(h_rdata), 8'hA5);
        chk("rd_e_rvalid", int'(e_rvalid), 0);

        // Round-robin: pointer now favours E, so E, H, E, H ...
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 15)), 8'h00, 1'b1, 1'b0, 8'($urandom_range(0, 15)));
            if (i > 0) begin
                chk("rr_e_gnt", int'(e_gnt), i % 2);
                chk("rr_h_gnt", int'(h_gnt), 1 - (i % 2));
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // Locked host burst against a waiting engine
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'b1, 1'b0, 8'h30);
            if (e_gnt) seen = 1'b1;
            else if (h_gnt && mem_en) cnt++;
        end
        chk("lock_burst_len", cnt, MAX_HOLD);
        chk("lock_handoff_e", int'(seen), 1);

        // Engine owner drops as host raises: no idle bubble
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h31);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h32);
        chk("handover_e_owns", int'(e_gnt), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("handover_h_gnt", int'(h_gnt), 1);
        chk("handover_e_gnt", int'(e_gnt), 0);

        // Reset lands on the edge right after an engine read of 0x20
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20);
        chk("mid_rd_e_gnt", int'(e_gnt), 1);
        chk("mid_rd_addr", int'(mem_addr), 8'h20);
        chk("mid_rd_en", int'(mem_en & ~mem_we), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("mid_rd_no_rvalid", int'(e_rvalid), 0);
        chk("mid_rd_idle", int'(h_gnt | e_gnt), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("mid_rd_no_rvalid2", int'(e_rvalid), 0);

        // Random traffic over a small address window so reads hit recent writes
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 15)), 8'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                8'($urandom_range(0, 15)));
        end

        @(negedge Clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
